// File: rtl/rgb_pwm_bank.sv
// Multi-channel PWM bank for the RGB LED driver: shared prescaler and period counter,
// per-channel duty/mode registers with a shadow duty that only changes at period wrap.
module rgb_pwm_bank #(
  parameter int NUM_CH     = 3,
  parameter int PWM_W      = 8,
  parameter int PRESC_W    = 16,
  parameter int BLINK_LOG2 = 6,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_wdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_t;

  // Last counter value before wrap is MAX-1 = 2^PWM_W - 2
  localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [PRESC_W-1:0]  presc_div;
  logic [PRESC_W-1:0]  presc_cnt;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [BLINK_LOG2:0] blink_cnt;

  logic [PWM_W-1:0]    duty     [NUM_CH];
  mode_t               mode     [NUM_CH];
  logic [PWM_W-1:0]    eff      [NUM_CH];
  logic [PWM_W-1:0]    lvl      [NUM_CH];
  logic                dir_down [NUM_CH];

  logic [PWM_W-1:0]    eff_nxt  [NUM_CH];
  logic [PWM_W-1:0]    lvl_nxt  [NUM_CH];
  logic                dir_nxt  [NUM_CH];
  logic [NUM_CH-1:0]   ch_hit;

  logic tick;
  logic boundary;
  logic wr_duty;
  logic wr_mode;
  logic wr_div;
  logic unused_wdata;

  assign tick     = enable && (presc_cnt == presc_div);
  assign boundary = tick && (pwm_cnt == CNT_LAST);

  assign wr_duty  = cfg_we && (cfg_sel == 2'd0);
  assign wr_mode  = cfg_we && (cfg_sel == 2'd1);
  assign wr_div   = cfg_we && (cfg_sel == 2'd2);

  assign unused_wdata = ^cfg_wdata;

  // Out-of-range channel numbers match no channel, so those writes fall away
  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = (int'(cfg_ch) == i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lvl_nxt[i] = lvl[i];
      dir_nxt[i] = dir_down[i];
      eff_nxt[i] = '0;
      case (mode[i])
        MODE_STATIC: eff_nxt[i] = duty[i];
        MODE_BREATHE: begin
          if (!dir_down[i]) begin
            if (lvl[i] < duty[i]) begin
              lvl_nxt[i] = lvl[i] + PWM_W'(1);
            end else begin
              dir_nxt[i] = 1'b1;
              lvl_nxt[i] = duty[i];
            end
          end else if (lvl[i] != '0) begin
            lvl_nxt[i] = lvl[i] - PWM_W'(1);
          end else begin
            dir_nxt[i] = 1'b0;
          end
          eff_nxt[i] = lvl_nxt[i];
        end
        MODE_BLINK: eff_nxt[i] = blink_cnt[BLINK_LOG2] ? '0 : duty[i];
        default: eff_nxt[i] = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      presc_div    <= '0;
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
    end else begin
      if (wr_div) begin
        presc_div <= cfg_wdata[PRESC_W-1:0];
      end
      if (!enable) begin
        presc_cnt <= '0;
        pwm_cnt   <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
        pwm_cnt   <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + PWM_W'(1);
      end else begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end
      period_start <= boundary;
      if (boundary) begin
        blink_cnt <= blink_cnt + (BLINK_LOG2+1)'(1);
      end
      // eff changes on the same edge pwm_cnt wraps, so the compare never mixes periods
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= enable & (pwm_cnt < eff[i]);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty[i]     <= '0;
        mode[i]     <= MODE_OFF;
        eff[i]      <= '0;
        lvl[i]      <= '0;
        dir_down[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty && ch_hit[i]) begin
          duty[i] <= cfg_wdata[PWM_W-1:0];
        end
        if (wr_mode && ch_hit[i]) begin
          mode[i] <= mode_t'(cfg_wdata[1:0]);
        end
        if (boundary) begin
          eff[i] <= eff_nxt[i];
        end
        // A mode write restarts the breathe ramp even if it lands on a wrap
        if (wr_mode && ch_hit[i]) begin
          lvl[i]      <= '0;
          dir_down[i] <= 1'b0;
        end else if (boundary) begin
          lvl[i]      <= lvl_nxt[i];
          dir_down[i] <= dir_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_bank.sv
// Scoreboard bench for rgb_pwm_bank: stimulus queues expected per-period high counts,
// a negedge monitor measures each period between period_start pulses and compares.
module tb_rgb_pwm_bank;

  localparam int TMO = 1500;

  logic       HCLK;
  logic       HRESET;
  logic       enable;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_sel;
  logic [31:0] cfg_wdata;
  logic [2:0] pwm_out;
  logic       period_start;

  typedef struct {
    int tag;
    int len;
    int h0;
    int h1;
    int h2;
  } exp_t;

  exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  int  br_exp [9] = '{1, 2, 3, 3, 2, 1, 0, 0, 1};
  int  bl_exp [5] = '{0, 0, 40, 40, 0};

  rgb_pwm_bank #(
    .NUM_CH(3),
    .PWM_W(8),
    .PRESC_W(16),
    .BLINK_LOG2(1)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .enable(enable),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata),
    .pwm_out(pwm_out),
    .period_start(period_start)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Monitor: a window spans the samples after one period_start up to and including the next
  bit armed = 1'b0;
  int  m_len, m_h0, m_h1, m_h2;
  always @(negedge HCLK) begin
    if (HRESET || !enable) begin
      armed = 1'b0;
      m_len = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      if (armed) begin
        m_len++;
        m_h0 += int'(pwm_out[0]);
        m_h1 += int'(pwm_out[1]);
        m_h2 += int'(pwm_out[2]);
      end
      if (period_start) begin
        if (armed && exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          vectors++;
          if (e.len != m_len || e.h0 != m_h0 || e.h1 != m_h1 || e.h2 != m_h2) begin
            miscompares++;
            $display("FAIL window_tag%0d: len/h0/h1/h2 got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     e.tag, m_len, m_h0, m_h1, m_h2, e.len, e.h0, e.h1, e.h2);
          end
        end
        armed = 1'b1;
        m_len = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0;
      end
    end
  end

  task automatic push(input int tag, input int len, input int h0, input int h1, input int h2);
    exp_t e;
    e.tag = tag; e.len = len; e.h0 = h0; e.h1 = h1; e.h2 = h2;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_sel   = 2'(sel);
    cfg_wdata = data;
    @(negedge HCLK);
    #1;
    cfg_we    = 1'b0;
  endtask

  // Returns just after the negedge on which period_start is seen; n = cycles waited
  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!period_start && n < TMO);
    if (!period_start) begin
      vectors++;
      miscompares++;
      $display("FAIL period_timeout: got no period_start after %0d cycles", n);
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    HRESET = 1'b1; enable = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;
    repeat (3) @(negedge HCLK);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    #1 HRESET = 1'b0;

    // Static duty 64 on ch0
    cfg_write(0, 1, 1);
    cfg_write(0, 0, 64);
    enable = 1'b1;
    wait_ps(n);
    check("first_period_len", n, 255);
    for (int k = 0; k < 3; k++) begin
      push(1, 255, 64, 0, 0);
      wait_ps(n);
    end

    // Duty extremes
    cfg_write(0, 0, 255);
    push(2, 255, 64, 0, 0);   wait_ps(n);
    push(3, 255, 255, 0, 0);  wait_ps(n);
    cfg_write(0, 0, 0);
    push(4, 255, 255, 0, 0);  wait_ps(n);
    push(5, 255, 0, 0, 0);    wait_ps(n);

    // Mid-period write
    cfg_write(0, 0, 64);
    push(6, 255, 0, 0, 0);    wait_ps(n);
    push(7, 255, 64, 0, 0);
    repeat (100) @(negedge HCLK);
    #1;
    cfg_write(0, 0, 200);
    wait_ps(n);
    push(8, 255, 200, 0, 0);  wait_ps(n);
    cfg_write(0, 0, 64);
    push(9, 255, 200, 0, 0);  wait_ps(n);

    // Write landing exactly on the wrap edge
    push(10, 255, 64, 0, 0);
    repeat (254) @(negedge HCLK);
    #1;
    cfg_write(0, 0, 200);
    check("boundary_write_aligned", int'(period_start), 1);
    push(11, 255, 64, 0, 0);  wait_ps(n);
    push(12, 255, 200, 0, 0); wait_ps(n);

    // Breathe on ch1, duty 3
    cfg_write(1, 0, 3);
    cfg_write(1, 1, 2);
    push(13, 255, 200, 0, 0); wait_ps(n);
    for (int k = 0; k < 9; k++) begin
      push(20 + k, 255, 200, br_exp[k], 0);
      wait_ps(n);
    end

    // Reset mid-period with a competing divider write
    repeat (100) @(negedge HCLK);
    #1;
    HRESET = 1'b1;
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_ch = 2'd0; cfg_wdata = 32'd1;
    @(negedge HCLK);
    check("midreset_pwm_out", int'(pwm_out), 0);
    check("midreset_period_start", int'(period_start), 0);
    #1;
    HRESET = 1'b0; cfg_we = 1'b0;
    wait_ps(n);
    check("post_reset_period_len", n, 255);
    push(30, 255, 0, 0, 0);   wait_ps(n);

    // Disable: outputs quiet, no period_start
    enable = 1'b0;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge HCLK);
      if (pwm_out != 3'b000 || period_start) bad++;
    end
    check("disabled_quiet_cycles_bad", bad, 0);
    #1;
    cfg_write(0, 2, 3);
    cfg_write(0, 0, 10);
    cfg_write(0, 1, 1);
    cfg_write(2, 0, 10);
    cfg_write(2, 1, 3);
    cfg_write(3, 0, 255);
    cfg_write(3, 1, 1);
    cfg_write(0, 3, 0);

    // Re-enable: prescaled period, blink on ch2 (blink_cnt is 2 after two wraps since reset)
    enable = 1'b1;
    wait_ps(n);
    check("reenable_period_len", n, 1020);
    for (int k = 0; k < 5; k++) begin
      push(40 + k, 1020, 40, 0, bl_exp[k]);
      wait_ps(n);
    end

    // Second reset mid-period: divider, duty and modes back to defaults
    repeat (300) @(negedge HCLK);
    #1;
    HRESET = 1'b1;
    @(negedge HCLK);
    check("reset2_pwm_out", int'(pwm_out), 0);
    #1;
    HRESET = 1'b0;
    wait_ps(n);
    check("reset2_period_len", n, 255);
    push(50, 255, 0, 0, 0);   wait_ps(n);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_bank.md
# rgb_pwm_bank

Parametrised multi-channel PWM generator for the on-board RGB LED path. It replaces raw GPIO bits driving the `SB_RGBA_DRV` PWM inputs with one registered, glitch-free PWM output per channel. Each channel has its own duty and mode (off, static, breathe, blink). It sits between the SoC (configuration write port, fed from GPIO or a bus bridge) and the `RGBxPWM` pins of the LED driver primitive.

## Interface
Parameters:
- `NUM_CH`, 3: number of PWM channels.
- `PWM_W`, 8: duty/counter width. `MAX = 2^PWM_W - 1`.
- `PRESC_W`, 16: prescaler divider width.
- `BLINK_LOG2`, 6: blink phase toggles every `2^BLINK_LOG2` PWM periods.

Ports:
- `HCLK` in 1: the single clock.
- `HRESET` in 1: synchronous, active-high reset.
- `enable` in 1: global run enable.
- `cfg_we` in 1: configuration write strobe, single cycle, always accepted.
- `cfg_ch` in `max(1,$clog2(NUM_CH))`: target channel.
- `cfg_sel` in 2: 0 = duty, 1 = mode, 2 = prescaler divider (global; `cfg_ch` ignored), 3 = ignored.
- `cfg_wdata` in 32: write data, low bits used.
- `pwm_out` out `NUM_CH`: registered PWM outputs, bit i goes to channel i.
- `period_start` out 1: one-cycle pulse at each PWM period wrap.

## Operation
- **Writes.**
  - Writes with `cfg_ch >= NUM_CH` or `cfg_sel == 3` are dropped.
  - Duty takes `cfg_wdata[PWM_W-1:0]`. Mode takes `cfg_wdata[1:0]`. Divider takes `cfg_wdata[PRESC_W-1:0]`.
- **Prescaler.**
  - `presc_cnt` counts 0..`presc_div`. `tick` is asserted when `presc_cnt == presc_div`, and `presc_cnt` returns to 0 on that cycle.
- **PWM counter.**
  - `pwm_cnt` increments on `tick` and counts 0..`MAX-1`.
  - A `tick` at `MAX-1` is a period boundary: `pwm_cnt` goes to 0 and `period_start` pulses on the next cycle.
- **Boundary update.** Once per boundary, for each channel, the shadow `eff[i]` is loaded from the active registers:
  - Mode 0 OFF: `eff = 0`.
  - Mode 1 STATIC: `eff = duty`.
  - Mode 2 BREATHE, using per-channel `lvl` and `dir`:
    - Up and `lvl < duty`: `lvl + 1`.
    - Up and `lvl >= duty`: `dir` becomes down, `lvl = duty`.
    - Down and `lvl > 0`: `lvl - 1`.
    - Down and `lvl == 0`: `dir` becomes up.
    - Then `eff = lvl`.
  - Mode 3 BLINK: `eff = blink_cnt[BLINK_LOG2] ? 0 : duty`. `blink_cnt` is a shared counter that increments each boundary and wraps.
- **Output compare.** `pwm_out[i] <= enable & (pwm_cnt < eff[i])`.
  - Duty `MAX` means always high. Duty 0 means always low. There is no glitch at the wrap.
- **Mode write.** Resets that channel's `lvl` to 0 and `dir` to up. It takes effect at the next boundary.
- **Write on a boundary cycle.** The shadow loads the pre-write value, so the write takes effect one period later.
- **`enable = 0`.** `presc_cnt` and `pwm_cnt` are held at 0, `pwm_out = 0`, and no `period_start` is generated. Config writes still land, and `lvl`, `dir` and `blink_cnt` hold.

## Timing
- **Reset values** (the cycle after `HRESET` is sampled high):
  - Outputs: `pwm_out = 0`, `period_start = 0`.
  - Registers: `presc_div = 0`, all duty = 0, all mode = OFF.
  - Counters and state: `pwm_cnt = 0`, `presc_cnt = 0`, `eff = 0`, `lvl = 0`, `dir` = up, `blink_cnt = 0`.
- **Reset precedence.** `HRESET` overrides everything, including a simultaneous `cfg_we`.
- **Period length.** `MAX*(presc_div+1)` cycles. High time is `eff*(presc_div+1)` cycles.
- **Latency.**
  - `pwm_out` lags the `pwm_cnt` compare by 1 cycle.
  - A config change is visible from the first period after the next boundary.
- **Divider change.** Applies immediately. If `presc_cnt > new presc_div`, `presc_cnt` keeps counting and wraps at `2^PRESC_W`; software writes the divider only while `enable = 0`.

## Test plan
- **Static duty.** Reset, `PWM_W = 8`, divider 0, ch0 STATIC with duty 64, `enable = 1`. Required: after the first boundary, every 255-cycle period has `pwm_out[0]` high for exactly 64 cycles, `period_start` pulses every 255 cycles, and ch1/ch2 stay 0.
- **Duty extremes.** Duty 255, then duty 0. Required: `pwm_out[0]` is constant 1 for a full period, then constant 0, with no single-cycle glitch at the wraps.
- **Mid-period write.** Write duty 200 mid-period, and separately write exactly on a boundary cycle. Required: the current period keeps 64. The first write shows 200 in the next period; the boundary-cycle write shows 200 one period later.
- **Breathe.** ch1 BREATHE with duty 3. Required: per-period high counts are 1, 2, 3, 3, 2, 1, 0, 0, 1.
- **Prescaler and blink.** Divider 3 with duty 10. Required: period 1020 cycles, 40 high. BLINK with `BLINK_LOG2 = 1`: 2 periods on, 2 periods off.
- **Reset and enable.** Assert `HRESET` mid-period. Required: next cycle all outputs 0 and every register at its default. Deassert `enable`: `pwm_out = 0` and no `period_start`. Re-enable: the period restarts from `pwm_cnt = 0`.
